// File: rtl/read_ahead_buf_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : read_ahead_buf_n_if
//  Description : Bundles the upstream FWFT-fifo read port and the consumer
//                pop port of the multi-word read-ahead buffer.
//                slave  = the buffer itself, master = the surrounding logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface read_ahead_buf_n_if #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int USEDW_W = $clog2(DEPTH + 1)
);
    // Control
    logic                flush;
    // Upstream FWFT fifo read port
    logic                fifo_r_req;
    logic [DATA_W-1:0]   fifo_r_data;
    logic                fifo_empty;
    // Consumer side
    logic                r_req;
    logic [DATA_W-1:0]   r_data;
    logic                empty;
    logic                full;
    logic                almost_empty;
    logic [USEDW_W-1:0]  usedw;
    logic                underflow;

    modport slave (
        input  flush,
        input  fifo_r_data,
        input  fifo_empty,
        input  r_req,
        output fifo_r_req,
        output r_data,
        output empty,
        output full,
        output almost_empty,
        output usedw,
        output underflow
    );

    modport master (
        output flush,
        output fifo_r_data,
        output fifo_empty,
        output r_req,
        input  fifo_r_req,
        input  r_data,
        input  empty,
        input  full,
        input  almost_empty,
        input  usedw,
        input  underflow
    );
endinterface
`default_nettype wire

// File: rtl/read_ahead_buf_n.sv
`default_nettype none
// ============================================================================
//  Module      : read_ahead_buf_n
//  Description : Multi-word read-ahead buffer between an upstream FWFT fifo
//                and a consumer. Prefetches up to DEPTH words into a local
//                circular buffer and presents the head word combinationally.
//                Provides fill level, almost-empty, synchronous flush and
//                a registered one-cycle underflow pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module read_ahead_buf_n #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int AE_LEVEL = 1,
    parameter int USEDW_W  = $clog2(DEPTH + 1)
) (
    input  wire                 clk,
    input  wire                 rst,
    read_ahead_buf_n_if.slave   bus
);

    // Pointer width; a one-word buffer still gets a 1-bit pointer that
    // only ever holds zero.
    localparam int                   c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0]   c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [USEDW_W-1:0]   c_depth    = USEDW_W'(DEPTH);
    localparam logic [USEDW_W-1:0]   c_ae_level = USEDW_W'(AE_LEVEL);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [USEDW_W-1:0]  count_q,  count_d;
    logic                underflow_q, underflow_d;

    // ------------------------------------------------------------------------
    // Combinational status and handshakes
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Status flags come only from registered count.
    always_comb begin
        w_empty = (count_q == '0);
        w_full  = (count_q == c_depth);
    end

    // Pop/push qualification; a pop frees a slot in the same cycle, which
    // lets a full buffer sustain one word per cycle.
    always_comb begin
        w_pop  = bus.r_req && !w_empty && !bus.flush;
        w_push = !rst && !bus.flush && !bus.fifo_empty && (!w_full || w_pop);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------

    // Storage write: the upstream head word lands at wr_ptr on a push.
    always_comb begin
        mem_d = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = bus.fifo_r_data;
        end
    end

    // Pointers, fill count and underflow flag; flush returns to the empty
    // origin without touching the upstream fifo.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        underflow_d = bus.r_req && w_empty && !bus.flush;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (w_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + USEDW_W'(1);
                2'b01:   count_d = count_q - USEDW_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // Control state, reset has priority over flush and everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Data array is not reset; stale words are hidden by the empty gate.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Head word is gated to zero while empty so stale storage never leaks.
    always_comb begin
        bus.fifo_r_req   = w_push;
        bus.r_data       = w_empty ? '0 : mem_q[rd_ptr_q];
        bus.empty        = w_empty;
        bus.full         = w_full;
        bus.almost_empty = (count_q <= c_ae_level);
        bus.usedw        = count_q;
        bus.underflow    = underflow_q;
    end

endmodule
`default_nettype wire

// File: doc/read_ahead_buf_n.md
Name: read_ahead_buf_n

Overview:
- Parametrised multi-word read-ahead buffer between a FWFT fifo read port and a consumer.
- Prefetches up to DEPTH words from the upstream fifo into a local circular buffer.
- Presents the head word combinationally, so the consumer can sample r_data in the same always_ff that issues r_req.
- Successor to the single-word read-ahead buffer. Adds configurable depth, fill level, almost-empty, synchronous flush and underflow detection.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 4, local buffer depth in words; legal values 1..256.
- AE_LEVEL, 1, almost_empty asserts when usedw <= AE_LEVEL; legal values 0..DEPTH.
- USEDW_W, $clog2(DEPTH+1), width of usedw; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of local buffer contents.
- fifo_r_req  out  1  pop strobe to upstream FWFT fifo.
- fifo_r_data  in  DATA_W  upstream head word; valid when ~fifo_empty.
- fifo_empty  in  1  upstream empty flag.
- r_req  in  1  consumer pop request.
- r_data  out  DATA_W  head word of local buffer.
- empty  out  1  local buffer empty.
- full  out  1  local buffer holds DEPTH words.
- almost_empty  out  1  usedw <= AE_LEVEL.
- usedw  out  USEDW_W  words currently held locally.
- underflow  out  1  one-cycle error pulse.

Behaviour:
- Storage:
  - DEPTH x DATA_W register array, rd_ptr/wr_ptr wrap modulo DEPTH (DEPTH need not be a power of two), count register 0..DEPTH.
  - empty = (count==0), full = (count==DEPTH), usedw = count. All are registered-state derived, no combinational path from inputs.
- Pop:
  - pop = r_req && ~empty && ~flush.
  - Consumes mem[rd_ptr] at the clock edge. r_data shows the next word from the following cycle.
- Push:
  - fifo_r_req = ~rst && ~flush && ~fifo_empty && (~full || pop). This is combinational.
  - On fifo_r_req, fifo_r_data is written to mem[wr_ptr] at the same edge.
- Data output:
  - r_data = mem[rd_ptr] when ~empty, else all-zeros. Driven combinationally from registers.
- Latency:
  - A word accepted from upstream at edge N is visible on r_data with empty=0 after edge N. This gives one-cycle empty deassertion latency from the fifo_empty fall.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - At count==1, r_data switches to the newly pushed word after the edge.
  - At full, push is permitted only together with pop, so DEPTH words are sustained at 1 word/cycle throughput.
- Pop while empty:
  - Ignored; no state change.
  - underflow is high for exactly the next cycle (registered).
  - r_req while empty and flush together does not flag underflow.
- Flush:
  - count=0, rd_ptr=wr_ptr=0 at the edge.
  - fifo_r_req is forced 0 in the flush cycle, so the upstream fifo is untouched.
  - r_req in the flush cycle is ignored and is not an underflow.
  - Array contents are not cleared; r_data reads zero via the empty gate.
- Reset:
  - rst overrides flush and all other inputs.
  - Reset values: count=0, pointers=0, empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), usedw=0, underflow=0, r_data=0, fifo_r_req=0.
  - Reset mid-stream discards the buffered words; upstream words are not re-fetched.
- Prefetch:
  - The block fills autonomously whenever upstream is non-empty and space exists.
  - Effective fifo depth = upstream depth + DEPTH.
- Upstream contract:
  - fifo_r_req is never asserted while fifo_empty=1.

Test Plan:
- Reset then upstream fills 6 words (0x10..0x15), DEPTH=4, r_req=0 -> fifo_r_req high for 4 cycles; usedw 1,2,3,4; full=1; r_data=0x10; fifo_r_req=0 afterwards.
- From full, r_req held high for 6 cycles with upstream holding 2 remaining words -> r_data sequence 0x10..0x15 one per cycle; usedw stays 4 while upstream is non-empty, then falls 3,2,1,0; empty=1 after the last pop; no underflow.
- Empty buffer, single upstream word 0xAB appears and fifo_empty falls at cycle N -> fifo_r_req=1 in cycle N; empty=0 and r_data=0xAB from cycle N+1.
- r_req pulsed with empty=1 -> no pointer change; underflow=1 for exactly one cycle; usedw stays 0.
- usedw=3, flush=1 with r_req=1 and fifo_empty=0 -> fifo_r_req=0 that cycle; usedw=0, empty=1, r_data=0 next cycle; underflow=0; refill resumes the cycle after.
- rst asserted at usedw=2 during a simultaneous push/pop -> next cycle all outputs equal their reset values, and fifo_r_req=0 while rst=1.
- DEPTH=3 build, push/pop 10 words continuously -> correct order across pointer wrap; usedw constant.
